// File: rtl/adc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_pkg: shared types and constants for the ADC responder        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package adc_pkg;

  localparam int DATA_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_CMD        = 3'd2,
    ST_NULL       = 3'd3,
    ST_MSB_DATA   = 3'd4,
    ST_LSB_DATA   = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  // Positions of the command bits inside the captured command word
  localparam int CMD_SGL  = 0;
  localparam int CMD_ODD  = 1;
  localparam int CMD_MSBF = 2;

  // {SGL, ODD} channel encodings
  localparam logic [1:0] CH_DIFF_01 = 2'b00;
  localparam logic [1:0] CH_DIFF_10 = 2'b01;
  localparam logic [1:0] CH_SGL_CH0 = 2'b10;
  localparam logic [1:0] CH_SGL_CH1 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_edge_sync: multi-stage synchroniser with registered          |
// | rise/fall event detection for one serial pin                     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_q;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_sync <= RESET_VAL;
        else          r_sync <= d_i;
      end
    end else begin : g_chain
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_sync <= {SYNC_STAGES{RESET_VAL}};
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
      end
    end
  endgenerate

  assign w_q = r_sync[SYNC_STAGES-1];

  // Events are registered so pin-to-event latency is SYNC_STAGES+1 cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_q;
      r_rise <= w_q & ~r_prev;
      r_fall <= ~w_q & r_prev;
    end
  end

  assign q_o    = w_q;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule
`default_nettype wire

// File: rtl/adc_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_responder: SPI responder emulating a 2-channel serial ADC.   |
// | Optional macro ADC_RESP_LSBF_EN enables the LSB-first tail.      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module adc_responder
  import adc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              din_i,
  output logic              dout_o,
  input  logic [DATA_W-1:0] ch0_data_i,
  input  logic [DATA_W-1:0] ch1_data_i,
  output logic              sample_o,
  output logic [1:0]        chan_o,
  output logic              frame_done_o,
  output logic              frame_abort_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef ADC_RESP_LSBF_EN
  localparam logic c_lsbf_en = 1'b1;
`else
  localparam logic c_lsbf_en = 1'b0;
`endif

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_din, w_din_rise, w_din_fall;
  logic w_unused;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(sclk_i),
    .q_o(w_sclk_q), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cs_i),
    .q_o(w_cs_q), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(din_i),
    .q_o(w_din), .rise_o(w_din_rise), .fall_o(w_din_fall)
  );

  assign w_unused = ^{w_sclk_q, w_cs_q, w_din_rise, w_din_fall};

  state_t            r_state;
  logic [1:0]        r_bit_cnt;
  logic [2:0]        r_cmd;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_value;
  logic              r_dout;
  logic              r_sample;
  logic [1:0]        r_chan;
  logic              r_done;
  logic              r_abort;

  logic [DATA_W:0]   w_diff01;
  logic [DATA_W:0]   w_diff10;
  logic [DATA_W-1:0] w_conv;

  // Differences carry one extra bit; its sign selects the clamp to zero
  assign w_diff01 = {1'b0, ch0_data_i} - {1'b0, ch1_data_i};
  assign w_diff10 = {1'b0, ch1_data_i} - {1'b0, ch0_data_i};

  always_comb begin
    w_conv = '0;
    case ({r_cmd[CMD_SGL], r_cmd[CMD_ODD]})
      CH_SGL_CH0: w_conv = ch0_data_i;
      CH_SGL_CH1: w_conv = ch1_data_i;
      CH_DIFF_01: w_conv = w_diff01[DATA_W] ? '0 : w_diff01[DATA_W-1:0];
      CH_DIFF_10: w_conv = w_diff10[DATA_W] ? '0 : w_diff10[DATA_W-1:0];
      default:    w_conv = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 2'd0;
      r_cmd     <= 3'd0;
      r_idx     <= '0;
      r_value   <= '0;
      r_dout    <= 1'b0;
      r_sample  <= 1'b0;
      r_chan    <= 2'b00;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_dout    <= 1'b0;
        r_bit_cnt <= 2'd0;
        r_idx     <= '0;
        r_value   <= '0;
        if (r_state == ST_DONE)      r_done  <= 1'b1;
        else if (r_state != ST_IDLE) r_abort <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_dout <= 1'b0;
            if (w_cs_fall) r_state <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (w_sclk_rise && w_din) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= 2'd0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              case (r_bit_cnt)
                2'd0:    r_cmd[CMD_SGL]  <= w_din;
                2'd1:    r_cmd[CMD_ODD]  <= w_din;
                default: r_cmd[CMD_MSBF] <= w_din;
              endcase
              if (r_bit_cnt == 2'd2) begin
                r_value   <= w_conv;
                r_chan    <= {r_cmd[CMD_SGL], r_cmd[CMD_ODD]};
                r_sample  <= 1'b1;
                r_bit_cnt <= 2'd0;
                r_state   <= ST_NULL;
              end else begin
                r_bit_cnt <= r_bit_cnt + 2'd1;
              end
            end
          end
          ST_NULL: begin
            if (w_sclk_fall) begin
              r_dout  <= 1'b0;
              r_idx   <= IDX_W'(DATA_W - 1);
              r_state <= ST_MSB_DATA;
            end
          end
          ST_MSB_DATA: begin
            if (w_sclk_fall) begin
              r_dout <= r_value[r_idx];
              if (r_idx == '0) begin
                if (!r_cmd[CMD_MSBF] && c_lsbf_en) begin
                  r_idx   <= IDX_W'(1);
                  r_state <= ST_LSB_DATA;
                end else begin
                  r_state <= ST_DONE;
                end
              end else begin
                r_idx <= r_idx - IDX_W'(1);
              end
            end
          end
          ST_LSB_DATA: begin
            if (w_sclk_fall) begin
              r_dout <= r_value[r_idx];
              if (r_idx == IDX_W'(DATA_W - 1)) r_state <= ST_DONE;
              else                             r_idx   <= r_idx + IDX_W'(1);
            end
          end
          ST_DONE: begin
            // The last data bit stays on the pin until the following fall
            if (w_sclk_fall) r_dout <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dout_o        = r_dout;
  assign sample_o      = r_sample;
  assign chan_o        = r_chan;
  assign frame_done_o  = r_done;
  assign frame_abort_o = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_adc_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_adc_responder: self-checking bench driving SPI frames against |
// | an arithmetic reference of the ADC response                      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_adc_responder;

  localparam int DATA_W = 10;
  localparam int SYNC_STAGES = 2;
  localparam int HALF = 10;
`ifdef ADC_RESP_LSBF_EN
  localparam bit LSBF = 1'b1;
`else
  localparam bit LSBF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sclk = 1'b0;
  logic              cs = 1'b1;
  logic              din = 1'b0;
  logic              dout;
  logic [DATA_W-1:0] ch0 = '0;
  logic [DATA_W-1:0] ch1 = '0;
  logic              sample;
  logic [1:0]        chan;
  logic              frame_done;
  logic              frame_abort;

  int n_cmp = 0;
  int n_err = 0;
  int n_sample = 0;
  int n_done = 0;
  int n_abort = 0;
  logic [1:0] chan_at_sample = 2'b00;

  always #5 clk = ~clk;

  adc_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sclk_i(sclk), .cs_i(cs), .din_i(din),
    .dout_o(dout), .ch0_data_i(ch0), .ch1_data_i(ch1), .sample_o(sample),
    .chan_o(chan), .frame_done_o(frame_done), .frame_abort_o(frame_abort)
  );

  always @(negedge clk) begin
    if (sample) begin
      n_sample++;
      chan_at_sample = chan;
    end
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
  end

  function automatic int ref_value(input bit sgl, input bit odd, input int c0, input int c1);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? (c1 - c0) : (c0 - c1);
    return (d < 0) ? 0 : d;
  endfunction

  task automatic sclk_cycle(input logic b, output logic d);
    din = b;
    repeat (HALF) @(negedge clk);
    d = dout;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  // stop_after < 0 runs a full frame; otherwise CS rises after that many data bits
  task automatic run_frame(input string tag, input int lead, input bit sgl, input bit odd,
                           input bit msbf, input logic [DATA_W-1:0] c0,
                           input logic [DATA_W-1:0] c1, input int stop_after);
    bit   cmd_q[$];
    bit   exp_q[$];
    int   v;
    int   n_rise;
    bit   full;
    logic d;
    v = ref_value(sgl, odd, int'(c0), int'(c1));
    full = (stop_after < 0);
    for (int i = 0; i < lead; i++) cmd_q.push_back(1'b0);
    cmd_q.push_back(1'b1);
    cmd_q.push_back(sgl);
    cmd_q.push_back(odd);
    cmd_q.push_back(msbf);
    for (int i = 0; i < lead + 5; i++) exp_q.push_back(1'b0);
    for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(((v >> b) & 1) != 0);
    if (LSBF && !msbf)
      for (int b = 1; b < DATA_W; b++) exp_q.push_back(((v >> b) & 1) != 0);
    exp_q.push_back(1'b0);
    n_rise = full ? exp_q.size() : (lead + 5 + stop_after);

    ch0 = c0;
    ch1 = c1;
    @(negedge clk);
    n_sample = 0;
    n_done = 0;
    n_abort = 0;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int r = 0; r < n_rise; r++) begin
      sclk_cycle((r < cmd_q.size()) ? cmd_q[r] : 1'($urandom_range(0, 1)), d);
      n_cmp++;
      if (d !== exp_q[r]) begin
        n_err++;
        $display("FAIL %s dout@rise%0d: got %b expected %b", tag, r, d, exp_q[r]);
      end
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);

    n_cmp++;
    if (dout !== 1'b0) begin
      n_err++;
      $display("FAIL %s dout_idle: got %b expected 0", tag, dout);
    end
    n_cmp++;
    if (n_sample !== 1) begin
      n_err++;
      $display("FAIL %s sample_count: got %0d expected 1", tag, n_sample);
    end
    n_cmp++;
    if (chan_at_sample !== {sgl, odd}) begin
      n_err++;
      $display("FAIL %s chan: got %b expected %b", tag, chan_at_sample, {sgl, odd});
    end
    n_cmp++;
    if (n_done !== (full ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s done_count: got %0d expected %0d", tag, n_done, full ? 1 : 0);
    end
    n_cmp++;
    if (n_abort !== (full ? 0 : 1)) begin
      n_err++;
      $display("FAIL %s abort_count: got %0d expected %0d", tag, n_abort, full ? 0 : 1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_cmp++;
    if ({dout, sample, chan, frame_done, frame_abort} !== 6'b0) begin
      n_err++;
      $display("FAIL %s outputs: got dout=%b sample=%b chan=%b done=%b abort=%b expected all 0",
               tag, dout, sample, chan, frame_done, frame_abort);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_directed();
    run_frame("ch0_single", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h000, -1);
    run_frame("ch1_lead0",  1, 1'b1, 1'b1, 1'b1, 10'h000, 10'h0F3, -1);
    run_frame("diff_clamp", 0, 1'b0, 1'b0, 1'b1, 10'h100, 10'h180, -1);
    run_frame("diff_pos",   0, 1'b0, 1'b1, 1'b1, 10'h100, 10'h180, -1);
    run_frame("lsbf_tail",  0, 1'b1, 1'b0, 1'b0, 10'h301, 10'h000, -1);
  endtask

  task automatic test_abort();
    run_frame("abort", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h155, 6);
    run_frame("after_abort", 0, 1'b1, 1'b1, 1'b1, 10'h2A5, 10'h155, -1);
  endtask

  task automatic test_reset_mid_frame();
    logic d;
    ch0 = 10'h3FF;
    ch1 = 10'h000;
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk_cycle(1'b1, d);
    sclk_cycle(1'b1, d);
    sclk_cycle(1'b0, d);
    sclk_cycle(1'b1, d);
    sclk_cycle(1'b0, d);
    for (int i = 0; i < 3; i++) sclk_cycle(1'b0, d);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (dout !== 1'b1 || chan !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_pre: got dout=%b chan=%b expected dout=1 chan=10", dout, chan);
    end
    n_done = 0;
    n_abort = 0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("rst_mid_async");
    cs = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (n_done !== 0 || n_abort !== 0) begin
      n_err++;
      $display("FAIL rst_mid_pulses: got done=%0d abort=%0d expected 0/0", n_done, n_abort);
    end
    run_frame("after_reset", 0, 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h000, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_frame($sformatf("rand%0d", k), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                DATA_W'($urandom), DATA_W'($urandom), -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      run_frame($sformatf("b2b%0d", k), 0, 1'b0, 1'(k & 1), 1'b1,
                DATA_W'($urandom), DATA_W'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
